// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared constants and FSM state encoding for mul_sched
package mul_sched_pkg;

  localparam int G_ADDR_W_DEF  = 8;
  localparam int G_DAT_DEP_DEF = 173;
  localparam int G_DAT_W_DEF   = 64;
  localparam int N_JOB_DEF     = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] KICK  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_CLEAR = CLEAR,
    ST_KICK  = KICK,
    ST_WAIT  = WAIT,
    ST_NEXT  = NEXT,
    ST_FIN   = FIN
  } state_t;

endpackage

// File: rtl/mul_sched_if.sv
// rtl/mul_sched_if.sv - control, multiplier handshake and f-RAM clear port bundle of mul_sched
interface mul_sched_if import mul_sched_pkg::*; #(
  parameter int G_ADDR_W = G_ADDR_W_DEF,
  parameter int G_DAT_W  = G_DAT_W_DEF,
  parameter int N_JOB    = N_JOB_DEF,
  parameter int JOB_W    = (N_JOB > 1) ? $clog2(N_JOB) : 1
);

  logic                start_i;
  logic [N_JOB-1:0]    job_mask_i;
  logic                abort_i;
  logic                mul_done_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [JOB_W-1:0]    cur_job_o;
  logic [JOB_W-1:0]    h_bank_sel_o;
  logic [JOB_W-1:0]    f_bank_sel_o;
  logic                f_mux_sel_o;
  logic [G_ADDR_W-1:0] f_clr_addr_o;
  logic                f_clr_we_o;
  logic [G_DAT_W-1:0]  f_clr_dout_o;
  logic                mul_start_o;
  logic                mul_rst_b_o;

  modport master (
    input  start_i, job_mask_i, abort_i, mul_done_i,
    output busy_o, done_o, err_o, cur_job_o, h_bank_sel_o, f_bank_sel_o,
           f_mux_sel_o, f_clr_addr_o, f_clr_we_o, f_clr_dout_o,
           mul_start_o, mul_rst_b_o
  );

  modport slave (
    output start_i, job_mask_i, abort_i, mul_done_i,
    input  busy_o, done_o, err_o, cur_job_o, h_bank_sel_o, f_bank_sel_o,
           f_mux_sel_o, f_clr_addr_o, f_clr_we_o, f_clr_dout_o,
           mul_start_o, mul_rst_b_o
  );

endinterface

// File: rtl/mul_sched_wdog.sv
// rtl/mul_sched_wdog.sv - saturating per-job watchdog, used only when MUL_SCHED_WDOG_EN is defined
module mul_sched_wdog #(
  parameter int W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = &cnt_q;

endmodule

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - BIKE KeyGen multiplier job scheduler: bank select, f-bank clear, kick and wait
// Optional watchdog on the multiplier done pulse is built in when MUL_SCHED_WDOG_EN is defined.
module mul_sched import mul_sched_pkg::*; #(
  parameter int G_ADDR_W  = G_ADDR_W_DEF,
  parameter int G_DAT_DEP = G_DAT_DEP_DEF,
  parameter int G_DAT_W   = G_DAT_W_DEF,
  parameter int N_JOB     = N_JOB_DEF,
  parameter int JOB_W     = (N_JOB > 1) ? $clog2(N_JOB) : 1,
  parameter int WDOG_W    = 20
) (
  input logic         clk,
  input logic         rst,
  mul_sched_if.master bus
);

  localparam logic [G_ADDR_W-1:0] LAST_ADDR = G_ADDR_W'(G_DAT_DEP - 1);

  state_t              state_q;
  logic [N_JOB-1:0]    mask_q;
  logic [JOB_W-1:0]    job_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                mux_q;
  logic                we_q;
  logic [G_ADDR_W-1:0] addr_q;
  logic                mstart_q;
  logic                mrst_b_q;
  logic                wdog_exp;
  logic [JOB_W:0]      first_job;
  logic [JOB_W:0]      next_job;

  // MSB of the result flags "found"; the lowest set bit at or above lo wins.
  function automatic logic [JOB_W:0] find_job(input logic [N_JOB-1:0] mask,
                                              input logic [JOB_W:0]   lo);
    logic [JOB_W:0] res;
    res = '0;
    for (int i = N_JOB - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) res = {1'b1, JOB_W'(i)};
    end
    return res;
  endfunction

  assign first_job = find_job(bus.job_mask_i, '0);
  assign next_job  = find_job(mask_q, {1'b0, job_q} + (JOB_W + 1)'(1));

`ifdef MUL_SCHED_WDOG_EN
  mul_sched_wdog #(.W(WDOG_W)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_KICK),
    .en_i      (state_q == ST_WAIT),
    .expired_o (wdog_exp)
  );
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_W;
  assign wdog_exp    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      job_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mux_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      mstart_q <= 1'b0;
      mrst_b_q <= 1'b1;
    end else begin
      done_q   <= 1'b0;
      mstart_q <= 1'b0;
      mrst_b_q <= 1'b1;
      if (bus.abort_i && (state_q != ST_IDLE)) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        mux_q    <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= '0;
        mrst_b_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.start_i && !bus.abort_i) begin
              mask_q <= bus.job_mask_i;
              err_q  <= 1'b0;
              busy_q <= 1'b1;
              if (first_job[JOB_W]) begin
                job_q   <= first_job[JOB_W-1:0];
                mux_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= '0;
                state_q <= ST_CLEAR;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_FIN;
              end
            end
          end
          ST_CLEAR: begin
            if (addr_q == LAST_ADDR) begin
              we_q     <= 1'b0;
              addr_q   <= '0;
              mux_q    <= 1'b0;
              mstart_q <= 1'b1;
              state_q  <= ST_KICK;
            end else begin
              addr_q <= addr_q + G_ADDR_W'(1);
            end
          end
          ST_KICK: state_q <= ST_WAIT;
          ST_WAIT: begin
            // A done pulse in the expiry cycle still counts as success.
            if (bus.mul_done_i) begin
              state_q <= ST_NEXT;
            end else if (wdog_exp) begin
              err_q    <= 1'b1;
              mrst_b_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_FIN;
            end
          end
          ST_NEXT: begin
            if (next_job[JOB_W]) begin
              job_q   <= next_job[JOB_W-1:0];
              mux_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= '0;
              state_q <= ST_CLEAR;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
          ST_FIN: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.cur_job_o    = job_q;
  assign bus.h_bank_sel_o = job_q;
  assign bus.f_bank_sel_o = job_q;
  assign bus.f_mux_sel_o  = mux_q;
  assign bus.f_clr_addr_o = addr_q;
  assign bus.f_clr_we_o   = we_q;
  assign bus.f_clr_dout_o = '0;
  assign bus.mul_start_o  = mstart_q;
  assign bus.mul_rst_b_o  = mrst_b_q;

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - randomized self-checking bench for mul_sched against a job-level model
module tb_mul_sched;

  localparam int DEP = 173;
  localparam int WW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sched_if bus ();
  mul_sched #(.WDOG_W(WW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   vec = 0;
  int   errs = 0;
  int   cyc = 0;
  int   lat = 20;
  bit   mul_dead = 1'b0;
  logic model_done = 1'b0;
  logic glitch_done = 1'b0;

  assign bus.mul_done_i = model_done | glitch_done;

  logic [15:0] wr_q[$];
  logic [3:0]  ms_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          bad_dout = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.f_clr_we_o === 1'b1) begin
        wr_q.push_back({bus.f_mux_sel_o, bus.cur_job_o, bus.h_bank_sel_o, bus.f_bank_sel_o,
                        4'b0, bus.f_clr_addr_o});
        if (bus.f_clr_dout_o !== '0) bad_dout++;
      end
      if (bus.mul_start_o === 1'b1)
        ms_q.push_back({bus.f_mux_sel_o, bus.cur_job_o, bus.h_bank_sel_o, bus.f_bank_sel_o});
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Multiplier stand-in: done pulse arrives lat cycles after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mul_start_o === 1'b1 && !rst && !mul_dead) begin
        repeat (lat) @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_q.delete();
    ms_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    bad_dout = 0;
  endtask

  task automatic run(input logic [1:0] mask, input int latency, input bit glitch, input string tag);
    logic [15:0] ew[$];
    logic [3:0]  es[$];
    logic        jb;
    int          jobs, exp_n, t0, n, mis;
    jobs = 0;
    for (int j = 0; j < 2; j++) begin
      if (mask[j]) begin
        jobs++;
        jb = 1'(j);
        for (int a = 0; a < DEP; a++) ew.push_back({1'b1, jb, jb, jb, 4'b0, 8'(a)});
        es.push_back({1'b0, jb, jb, jb});
      end
    end
    exp_n = jobs * (DEP + 1 + latency + 1) + 1;
    lat = latency;
    clear_log();
    bus.job_mask_i = mask;
    bus.start_i    = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.job_mask_i = 2'($urandom);
    check({tag, ":busy_first"}, bus.busy_o, 1);
    if (glitch && mask != 2'b00) begin
      glitch_done = 1'b1;
      @(negedge clk);
      glitch_done = 1'b0;
      n = 0;
      while (ms_q.size() == 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
      bus.job_mask_i = ~mask;
      bus.start_i    = 1'b1;
      @(negedge clk);
      bus.start_i    = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < exp_n + 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":done_cycle"}, done_cyc - t0, exp_n);
    repeat (3) @(negedge clk);
    check({tag, ":done_pulses"}, done_cnt, 1);
    check({tag, ":busy_after"}, bus.busy_o, 0);
    check({tag, ":err"}, bus.err_o, 0);
    check({tag, ":wr_count"}, wr_q.size(), ew.size());
    mis = 0;
    for (int i = 0; i < ew.size() && i < wr_q.size(); i++) if (wr_q[i] !== ew[i]) mis++;
    check({tag, ":wr_seq"}, mis, 0);
    check({tag, ":kick_count"}, ms_q.size(), es.size());
    mis = 0;
    for (int i = 0; i < es.size() && i < ms_q.size(); i++) if (ms_q[i] !== es[i]) mis++;
    check({tag, ":kick_sel"}, mis, 0);
    check({tag, ":clr_dout"}, bad_dout, 0);
  endtask

  initial begin
    int n, t0;
    rst = 1'b1;
    bus.start_i    = 1'b0;
    bus.job_mask_i = '0;
    bus.abort_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:busy", bus.busy_o, 0);
    check("rst:done", bus.done_o, 0);
    check("rst:err", bus.err_o, 0);
    check("rst:cur_job", bus.cur_job_o, 0);
    check("rst:h_sel", bus.h_bank_sel_o, 0);
    check("rst:f_sel", bus.f_bank_sel_o, 0);
    check("rst:mux", bus.f_mux_sel_o, 0);
    check("rst:addr", bus.f_clr_addr_o, 0);
    check("rst:we", bus.f_clr_we_o, 0);
    check("rst:dout", bus.f_clr_dout_o, 0);
    check("rst:mul_start", bus.mul_start_o, 0);
    check("rst:mul_rst_b", bus.mul_rst_b_o, 1);
    rst = 1'b0;
    @(negedge clk);

    run(2'b11, 500, 1'b0, "m11");
    run(2'b10, $urandom_range(10, 60), 1'b0, "m10");
    run(2'b00, 20, 1'b0, "m00");
    run(2'b01, $urandom_range(10, 60), 1'b1, "glitch");

    // Abort in the middle of the first clear.
    lat = 30;
    clear_log();
    bus.job_mask_i = 2'b11;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (!(bus.f_clr_we_o === 1'b1 && bus.f_clr_addr_o === 8'd50) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort:reach_addr", bus.f_clr_addr_o, 50);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort:busy", bus.busy_o, 0);
    check("abort:mul_rst_b_low", bus.mul_rst_b_o, 0);
    check("abort:we", bus.f_clr_we_o, 0);
    check("abort:mux", bus.f_mux_sel_o, 0);
    @(negedge clk);
    check("abort:mul_rst_b_high", bus.mul_rst_b_o, 1);
    repeat (20) @(negedge clk);
    check("abort:no_done", done_cnt, 0);
    check("abort:no_kick", ms_q.size(), 0);
    check("abort:writes", wr_q.size(), 51);
    run(2'b11, $urandom_range(10, 60), 1'b0, "post_abort");

    for (int k = 0; k < 4; k++)
      run(2'($urandom_range(0, 3)), $urandom_range(10, 60), 1'($urandom_range(0, 1)), "rand");

    // Asynchronous reset mid-clear.
    bus.job_mask_i = 2'b01;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst:busy", bus.busy_o, 0);
    check("arst:we", bus.f_clr_we_o, 0);
    check("arst:addr", bus.f_clr_addr_o, 0);
    check("arst:mux", bus.f_mux_sel_o, 0);
    check("arst:mul_rst_b", bus.mul_rst_b_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(2'b00, 20, 1'b0, "post_rst");

`ifdef MUL_SCHED_WDOG_EN
    mul_dead = 1'b1;
    clear_log();
    bus.job_mask_i = 2'b01;
    bus.start_i    = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.done_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wdog:done_cycle", cyc - t0, DEP + 1 + (1 << WW) + 1);
    check("wdog:err", bus.err_o, 1);
    check("wdog:mul_rst_b_low", bus.mul_rst_b_o, 0);
    @(negedge clk);
    check("wdog:mul_rst_b_high", bus.mul_rst_b_o, 1);
    check("wdog:busy", bus.busy_o, 0);
    check("wdog:err_sticky", bus.err_o, 1);
    mul_dead = 1'b0;
    run(2'b00, 20, 1'b0, "wdog_clear");
`else
    t0 = cyc;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Job scheduler for the sparse×dense polynomial multiplier in the BIKE KeyGen datapath.
- Runs up to N_JOB multiplications back-to-back, for example h0·g→f0 and h1·g→f1.
- Per job: selects the h and f memory banks, zero-clears the target f bank through an owned write port, kicks the multiplier, and waits for its done pulse.
- Sits between the KeyGen top-level FSM and the multiplier controller; owns the f-RAM port mux.

Parameters:
- G_ADDR_W, 8: dense/f RAM address width.
- G_DAT_DEP, 173: dense words per polynomial (clear length).
- G_DAT_W, 64: dense word width.
- N_JOB, 2: number of multiplication jobs / bank pairs.
- JOB_W, 1: width of bank-select index, $clog2(N_JOB) with minimum 1.
- WDOG_W, 20: width of the per-job watchdog counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a schedule; sampled only in IDLE.
- job_mask  in  N_JOB  jobs to run; latched on an accepted start.
- abort  in  1  cancel the schedule from any state.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at schedule end.
- err  out  1  sticky watchdog error; cleared by the next accepted start.
- cur_job  out  JOB_W  index of the job in progress.
- h_bank_sel  out  JOB_W  h-RAM bank for the multiplier.
- f_bank_sel  out  JOB_W  f-RAM bank for clear and multiplier.
- f_mux_sel  out  1  1 = scheduler owns the f port, 0 = multiplier owns it.
- f_clr_addr  out  G_ADDR_W  clear write address.
- f_clr_we  out  1  clear write enable.
- f_clr_dout  out  G_DAT_W  clear data, constant 0.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_done  in  1  one-cycle done pulse from the multiplier.
- mul_rst_b  out  1  synchronous active-low reset to the multiplier; pulsed low for 1 cycle on abort or watchdog expiry.

Behaviour:
- Reset values: every output 0 except mul_rst_b=1. State=IDLE; latched mask, wdog and job index all 0.
- States: IDLE, CLEAR, KICK, WAIT, NEXT, FIN. All outputs are registered.
- IDLE
  - start=1 latches job_mask and clears err.
  - mask==0 → FIN.
  - Otherwise cur_job/h_bank_sel/f_bank_sel = lowest set bit, → CLEAR.
  - start while not in IDLE is ignored.
- CLEAR
  - f_mux_sel=1, f_clr_we=1, f_clr_addr counts 0..G_DAT_DEP-1, one word per cycle: exactly G_DAT_DEP cycles.
  - Leaving CLEAR: f_clr_we=0, f_clr_addr=0, → KICK.
- KICK
  - mul_start=1 for exactly one cycle, f_mux_sel=0, wdog=0, → WAIT.
- WAIT
  - wdog increments and saturates.
  - mul_done=1 → NEXT.
  - With the optional feature, wdog reaching all-ones before mul_done: err=1, mul_rst_b=0 for one cycle, → FIN.
  - mul_done and expiry in the same cycle: done wins, no error.
- NEXT
  - Search for the next set mask bit strictly above cur_job.
  - Found → update cur_job and bank selects, → CLEAR.
  - None → FIN.
- FIN
  - done=1 for one cycle, busy=0 next cycle, → IDLE.
  - Bank selects hold their last values.
- abort (any non-IDLE state)
  - Next cycle: IDLE, busy=0, mul_rst_b=0 for one cycle, f_clr_we=0, f_mux_sel=0, no done pulse.
  - abort wins over a simultaneous start or mul_done.
  - abort in IDLE has no effect.
- mul_done outside WAIT is ignored.
- Reset mid-operation returns immediately to reset values.
- Cycle budget per job: G_DAT_DEP + 1 (KICK) + multiplier latency + 1 (NEXT). FIN adds 1 cycle.

Optional Feature:
- Macro: MUL_SCHED_WDOG_EN.
- Defined: watchdog as above; expiry at 2^WDOG_W-1 cycles in WAIT.
- Undefined: no wdog counter; err is tied 0; WAIT waits indefinitely for mul_done or abort.

Decomposition:
- Package mul_sched_pkg holds:
  - state encoding localparams IDLE=0, CLEAR=1, KICK=2, WAIT=3, NEXT=4, FIN=5;
  - the default G_DAT_DEP/G_ADDR_W constants shared with the multiplier.
- Sub-module mul_sched_wdog holds the counter with clear/enable/expired; instantiated only under MUL_SCHED_WDOG_EN.
- Next-job search is an in-module function.

Test Plan:
- Mask 2'b11, model multiplier returns mul_done 500 cycles after mul_start:
  - 173 clear writes to bank 0 (addr 0..172), one mul_start with selects 0;
  - then 173 writes to bank 1, mul_start with selects 1;
  - one done pulse; total from start to done = 2·(173+1+500+1)+1 cycles.
- Mask 2'b10: only job 1 runs; no bank-0 writes; cur_job=1 throughout; one done pulse.
- Mask 2'b00: done pulses on the second cycle after start; no f_clr_we, no mul_start.
- Abort asserted at clear address 50: next cycle IDLE, busy=0, mul_rst_b low for 1 cycle, no done; a fresh start then runs normally.
- MUL_SCHED_WDOG_EN with WDOG_W=8, mul_done never arrives: err=1, mul_rst_b pulse, done 1 cycle after expiry; the next start clears err.
- start pulsed during WAIT, and mul_done pulsed during CLEAR: both ignored, schedule unchanged.
